button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 500000; clk cycles an input must hold stable before a level change is accepted.
REQ-002 SHALL have parameter RPT_DELAY, default 25000000; clk cycles a debounced addr press must be held before auto-repeat starts.
REQ-003 SHALL have parameter RPT_PERIOD, default 5000000; clk cycles between auto-repeat pulses.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port addr_step, input, 1, raw asynchronous address-step button.
REQ-007 SHALL have port we_step, input, 1, raw asynchronous write button.
REQ-008 SHALL have port addr_pulse, output, 1, one-clk strobe that advances the address sequencer.
REQ-009 SHALL have port wr_pulse, output, 1, one-clk RAM write strobe.
REQ-010 SHALL have port addr_held, output, 1, debounced addr_step level.
REQ-011 SHALL have port we_held, output, 1, debounced we_step level.

Function
REQ-012 SHALL pass each raw input through a 2-flop synchronizer; all later logic SHALL use only the synchronized value.
REQ-013 SHALL give each button an independent FSM with states IDLE, DEB_PRESS, PRESSED, DEB_RELEASE.
REQ-014 IDLE: a synchronized 1 SHALL enter DEB_PRESS and clear that button's counter.
REQ-015 DEB_PRESS: a 0 SHALL return to IDLE; DB_CYCLES consecutive 1s SHALL enter PRESSED and set the held output.
REQ-016 PRESSED: a 0 SHALL enter DEB_RELEASE and clear the counter.
REQ-017 DEB_RELEASE: a 1 SHALL return to PRESSED; DB_CYCLES consecutive 0s SHALL enter IDLE and clear the held output.
REQ-018 Entry into PRESSED from DEB_PRESS SHALL produce exactly one press event; PRESSED re-entered from DEB_RELEASE SHALL NOT produce one.
REQ-019 The end-to-end latency from the first synchronized 1 to the strobe SHALL be exactly DB_CYCLES+1 clk cycles; the synchronizer adds 2 more.
REQ-020 Every strobe SHALL last exactly one clk cycle; addr_pulse and wr_pulse SHALL never be high in the same cycle.
REQ-021 Simultaneous events: if an addr event and a wr event occur in the same cycle, wr_pulse SHALL issue that cycle and addr_pulse SHALL issue the next cycle; RAM therefore writes at the pre-step address.
REQ-022 Each event SHALL be held in a one-deep pending flag until issued; a second event arriving while the flag is already set SHALL be dropped.
REQ-023 Counters SHALL saturate at their terminal value and SHALL never wrap; counter width SHALL be large enough to hold the largest parameter.

Reset
REQ-024 reset SHALL force, on the next clk edge: both FSMs to IDLE, counters and pending flags to 0, synchronizers to 0, and all four outputs to 0.
REQ-025 An assertion of reset mid-debounce or mid-repeat SHALL discard that event; a button still held after reset releases SHALL be re-debounced and counted as a new press.

Configuration
REQ-026 Macro AUTO_REPEAT_EN, when defined, SHALL add repeat logic to the addr button: after RPT_DELAY cycles in PRESSED, one addr event fires, then one more every RPT_PERIOD cycles until the button leaves PRESSED.
REQ-027 With AUTO_REPEAT_EN defined, repeat events SHALL obey REQ-020 to REQ-022, and the repeat timer SHALL reset whenever the addr FSM leaves PRESSED.
REQ-028 With AUTO_REPEAT_EN undefined, there SHALL be no repeat logic, and one addr press SHALL yield exactly one addr_pulse; we_step SHALL never auto-repeat in either build.

Verification (DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=5)
REQ-029 Drive addr_step high for 10 cycles -> addr_pulse high for exactly 1 cycle, 7 cycles after the rising edge; addr_held goes 1.
REQ-030 Toggle we_step with 3-cycle high/low bounces, then hold it high -> no wr_pulse during bounces; one wr_pulse after the stable hold.
REQ-031 Release both buttons together, then press both together -> wr_pulse in cycle N, addr_pulse in cycle N+1, never overlapping.
REQ-032 Assert reset for 1 cycle at debounce count 2 while addr_step stays high -> no pulse before reset; one addr_pulse 7 cycles after reset releases; all outputs 0 during reset.
REQ-033 With AUTO_REPEAT_EN defined, hold addr_step for 50 cycles -> the initial pulse, then a pulse 20 cycles later, then pulses every 5 cycles until release; without the macro, the same hold gives exactly 1 pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// Debounces two raw push-buttons and turns accepted presses into one-clk address-step and write strobes.
// Define AUTO_REPEAT_EN to add hold-to-repeat behaviour on the address button.
module button_conditioner #(
    parameter int DB_CYCLES  = 500000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic addr_step,
    input  logic we_step,
    output logic addr_pulse,
    output logic wr_pulse,
    output logic addr_held,
    output logic we_held
);

    localparam int MAX_A = (DB_CYCLES > RPT_DELAY) ? DB_CYCLES : RPT_DELAY;
    localparam int MAX_P = (MAX_A > RPT_PERIOD) ? MAX_A : RPT_PERIOD;
    localparam int CW    = $clog2(MAX_P + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

    logic [1:0] raw;
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] held;
    logic [1:0] evt;
    logic       addr_pend;
    logic       addr_req;
    logic       wr_req;

    // Bit 0 is the address button, bit 1 the write button.
    assign raw = {we_step, addr_step};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        state_t        state;
        logic [CW-1:0] cnt;
        logic          held_r;
        logic          press_evt;
        logic          rpt_evt;

        // The strobe is raised on the same edge that accepts the press.
        assign press_evt = (state == DEB_PRESS) && sync_p1[i] && (cnt == DB_LAST);
        assign held[i]   = held_r;
        assign evt[i]    = press_evt | rpt_evt;

        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= IDLE;
                cnt    <= '0;
                held_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sync_p1[i]) begin
                            state <= DEB_PRESS;
                            cnt   <= '0;
                        end
                    end
                    DEB_PRESS: begin
                        if (!sync_p1[i]) begin
                            state <= IDLE;
                        end else if (cnt == DB_LAST) begin
                            state  <= PRESSED;
                            held_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!sync_p1[i]) begin
                            state <= DEB_RELEASE;
                            cnt   <= '0;
                        end
                    end
                    DEB_RELEASE: begin
                        if (sync_p1[i]) begin
                            state <= PRESSED;
                        end else if (cnt == DB_LAST) begin
                            state  <= IDLE;
                            held_r <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

`ifdef AUTO_REPEAT_EN
        if (i == 0) begin : g_rpt
            localparam logic [CW-1:0] DELAY_LAST  = CW'(RPT_DELAY - 1);
            localparam logic [CW-1:0] PERIOD_LAST = CW'(RPT_PERIOD - 1);
            logic [CW-1:0] rpt_cnt;
            logic          rpt_phase;
            logic [CW-1:0] rpt_last;

            // First repeat waits the long delay, later ones the short period.
            assign rpt_last = rpt_phase ? PERIOD_LAST : DELAY_LAST;
            assign rpt_evt  = (state == PRESSED) && sync_p1[i] && (rpt_cnt == rpt_last);

            always_ff @(posedge clk) begin
                if (reset || (state != PRESSED)) begin
                    rpt_cnt   <= '0;
                    rpt_phase <= 1'b0;
                end else if (rpt_evt) begin
                    rpt_cnt   <= '0;
                    rpt_phase <= 1'b1;
                end else if (rpt_cnt != rpt_last) begin
                    rpt_cnt <= rpt_cnt + CW'(1);
                end
            end
        end else begin : g_norpt
            assign rpt_evt = 1'b0;
        end
`else
        assign rpt_evt = 1'b0;
`endif
    end

    // Write wins a tie so the RAM is written before the address advances.
    assign wr_req   = evt[1];
    assign addr_req = evt[0] | addr_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pulse   <= 1'b0;
            addr_pulse <= 1'b0;
            addr_pend  <= 1'b0;
        end else begin
            wr_pulse   <= wr_req;
            addr_pulse <= addr_req & ~wr_req;
            addr_pend  <= addr_req & wr_req;
        end
    end

    assign addr_held = held[0];
    assign we_held   = held[1];

endmodule
